// File: rtl/lut_curve_loader_if.sv
// Write port from the curve loader into lut_table: one address/value pair per wr_stb.
interface lut_ctrl_if #(
    parameter int PX_WIDTH = 10
);
    logic [PX_WIDTH-1:0] orig_px;
    logic [PX_WIDTH-1:0] mod_px;
    logic                wr_stb;

    modport master (output orig_px, output mod_px, output wr_stb);
    modport slave  (input  orig_px, input  mod_px, input  wr_stb);
endinterface

// File: rtl/lut_curve_loader.sv
// Fills lut_table with a clamped linear gain/offset curve, one entry per cycle.
// Define LUT_LOADER_FRAME_SYNC_EN to hold the rewrite until the next frame_end_i pulse.
module lut_curve_loader #(
    parameter int PX_WIDTH   = 10,
    parameter int GAIN_WIDTH = 12,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic        [GAIN_WIDTH-1:0] cfg_gain_i,
    input  logic signed [PX_WIDTH:0]     cfg_offset_i,
    input  logic                         cfg_start_i,
    input  logic                         frame_end_i,
    output logic                         busy_o,
    output logic                         done_o,
    lut_ctrl_if.master                   lut_ctrl_o
);

    localparam int PROD_W = PX_WIDTH + GAIN_WIDTH;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic        [PX_WIDTH-1:0] IDX_LAST = '1;
    localparam logic signed [SUM_W-1:0]    PX_MAX   = SUM_W'((1 << PX_WIDTH) - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef LUT_LOADER_FRAME_SYNC_EN
        ARMED,
`endif
        WRITE,
        FLUSH,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   issue;

    logic        [PX_WIDTH-1:0]   idx;
    logic        [GAIN_WIDTH-1:0] gain_sh;
    logic signed [PX_WIDTH:0]     offset_sh;

    logic                         vld_p1;
    logic        [PX_WIDTH-1:0]   idx_p1;
    logic        [PROD_W-1:0]     prod_p1;
    logic signed [SUM_W-1:0]      sum_p1;

    logic                         vld_p2;
    logic        [PX_WIDTH-1:0]   orig_p2;
    logic        [PX_WIDTH-1:0]   mod_p2;

    function automatic logic [PX_WIDTH-1:0] clamp_px(input logic signed [SUM_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > PX_MAX)
            return '1;
        else
            return v[PX_WIDTH-1:0];
    endfunction

`ifndef LUT_LOADER_FRAME_SYNC_EN
    logic unused_frame_end;
    assign unused_frame_end = frame_end_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start_i) begin
                    accept = 1'b1;
`ifdef LUT_LOADER_FRAME_SYNC_EN
                    state_nxt = ARMED;
`else
                    state_nxt = WRITE;
`endif
                end
            end
`ifdef LUT_LOADER_FRAME_SYNC_EN
            ARMED: begin
                if (frame_end_i)
                    state_nxt = WRITE;
            end
`endif
            WRITE: begin
                issue  = 1'b1;
                busy_o = 1'b1;
                if (idx == IDX_LAST)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                // Last entry leaves stage 1 this cycle; it strobes next cycle.
                busy_o = 1'b1;
                if (!vld_p1)
                    state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            idx <= '0;
        else if (issue)
            idx <= idx + PX_WIDTH'(1);
        else
            idx <= '0;
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            gain_sh   <= cfg_gain_i;
            offset_sh <= cfg_offset_i;
        end
    end

    // Stage 1: scale the address by the shadowed gain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= issue;
    end

    always_ff @(posedge clk_i) begin
        idx_p1  <= idx;
        prod_p1 <= PROD_W'(idx) * PROD_W'(gain_sh);
    end

    assign sum_p1 = $signed({1'b0, prod_p1 >> FRAC_BITS})
                  + $signed({{(SUM_W - PX_WIDTH - 1){offset_sh[PX_WIDTH]}}, offset_sh});

    // Stage 2: offset, clamp and present the write to lut_table
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2  <= 1'b0;
            orig_p2 <= '0;
            mod_p2  <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                orig_p2 <= idx_p1;
                mod_p2  <= clamp_px(sum_p1);
            end
        end
    end

    assign lut_ctrl_o.wr_stb  = vld_p2;
    assign lut_ctrl_o.orig_px = orig_p2;
    assign lut_ctrl_o.mod_px  = mod_p2;

endmodule

// File: tb/tb_lut_curve_loader.sv
// Randomized bench for lut_curve_loader: timing/value model derived from the curve rules.
module tb_lut_curve_loader;

    localparam int PXW = 10;
    localparam int GW  = 12;
    localparam int FB  = 8;
    localparam int N   = 1 << PXW;

    logic          clk = 1'b0;
    logic          rst;
    logic [GW-1:0] cfg_gain;
    logic [PXW:0]  cfg_offset;
    logic          cfg_start;
    logic          frame_end;
    logic          busy;
    logic          done;

    lut_ctrl_if #(.PX_WIDTH(PXW)) lut_bus ();

    lut_curve_loader #(
        .PX_WIDTH   (PXW),
        .GAIN_WIDTH (GW),
        .FRAC_BITS  (FB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_gain_i   (cfg_gain),
        .cfg_offset_i (cfg_offset),
        .cfg_start_i  (cfg_start),
        .frame_end_i  (frame_end),
        .busy_o       (busy),
        .done_o       (done),
        .lut_ctrl_o   (lut_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // Model: 0 idle, 1 waiting for frame end, 2 loading with write start at m_w
    int m_mode = 0;
    int m_w = 0;
    int m_gain = 0;
    int m_off = 0;

    int strobe_cnt, done_cnt, first_cyc, last_cyc, done_cyc, first_orig;
    int mod_seen [N];

    function automatic int ref_mod(input int k, input int g, input int o);
        int v;
        v = (k * g) / (1 << FB) + o;
        if (v < 0) return 0;
        if (v > N - 1) return N - 1;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int c;
        c = cyc;
        if (rst) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (cfg_start) begin
                    m_gain = int'(cfg_gain);
                    m_off  = int'($signed(cfg_offset));
`ifdef LUT_LOADER_FRAME_SYNC_EN
                    m_mode = 1;
`else
                    m_mode = 2;
                    m_w    = c + 1;
`endif
                end
                1: if (frame_end) begin
                    m_mode = 2;
                    m_w    = c + 1;
                end
                default: if (c >= m_w + N + 2) m_mode = 0;
            endcase
        end
        cyc = c + 1;
    end

    always @(negedge clk) begin
        int k;
        bit e_stb, e_busy, e_done;
        if (rst) begin
            check("rst_wr_stb", int'(lut_bus.wr_stb), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_orig", int'(lut_bus.orig_px), 0);
            check("rst_mod", int'(lut_bus.mod_px), 0);
        end else begin
            e_stb = 1'b0; e_busy = 1'b0; e_done = 1'b0; k = 0;
            if (m_mode == 2) begin
                k      = cyc - m_w - 2;
                e_stb  = (k >= 0 && k < N);
                e_busy = (cyc >= m_w && cyc <= m_w + N + 1);
                e_done = (cyc == m_w + N + 2);
            end
            check("wr_stb", int'(lut_bus.wr_stb), int'(e_stb));
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
            if (e_stb) begin
                check("orig_px", int'(lut_bus.orig_px), k);
                check("mod_px", int'(lut_bus.mod_px), ref_mod(k, m_gain, m_off));
            end
            if (lut_bus.wr_stb) begin
                if (strobe_cnt == 0) begin
                    first_cyc  = cyc;
                    first_orig = int'(lut_bus.orig_px);
                end
                strobe_cnt++;
                last_cyc = cyc;
                mod_seen[lut_bus.orig_px] = int'(lut_bus.mod_px);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        strobe_cnt = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1;
        done_cyc = -1; first_orig = -1;
        for (int i = 0; i < N; i++) mod_seen[i] = -1;
    endtask

    // Returns r such that the write phase begins at cycle r+1.
    task automatic kick(input int g, input int o, output int r);
        cfg_gain   = g[GW-1:0];
        cfg_offset = o[PXW:0];
        cfg_start  = 1'b1;
        frame_end  = 1'b1;
        r = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        frame_end = 1'b0;
`ifdef LUT_LOADER_FRAME_SYNC_EN
        repeat (49) begin @(posedge clk); #1; end
        frame_end = 1'b1;
        r = cyc;
        @(posedge clk); #1;
        frame_end = 1'b0;
`endif
    endtask

    task automatic wait_done(input bit noise);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else if (noise) begin
`ifndef LUT_LOADER_FRAME_SYNC_EN
                frame_end = ($urandom_range(0, 5) == 0);
`endif
                cfg_start = ($urandom_range(0, 40) == 0);
                cfg_gain  = GW'($urandom);
            end
        end
        cfg_start = 1'b0;
        frame_end = 1'b0;
        check("done_seen", int'(seen), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int r;
        bit hit;
        rst = 1'b1; cfg_gain = '0; cfg_offset = '0; cfg_start = 1'b0; frame_end = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        clear_stats(); kick(256, 0, r); wait_done(0);
        check("unity_first_cyc", first_cyc, r + 3);
        check("unity_last_cyc", last_cyc, r + 1026);
        check("unity_done_cyc", done_cyc, r + 1027);
        check("unity_strobes", strobe_cnt, 1024);
        check("unity_dones", done_cnt, 1);
        check("unity_mod5", mod_seen[5], 5);
        check("unity_mod1023", mod_seen[1023], 1023);

        clear_stats(); kick(512, 0, r); wait_done(0);
        check("x2_mod100", mod_seen[100], 200);
        check("x2_mod511", mod_seen[511], 1022);
        check("x2_mod512", mod_seen[512], 1023);
        check("x2_mod600", mod_seen[600], 1023);

        clear_stats(); kick(256, -100, r); wait_done(0);
        check("neg_mod50", mod_seen[50], 0);
        check("neg_mod100", mod_seen[100], 0);
        check("neg_mod101", mod_seen[101], 1);
        check("neg_mod300", mod_seen[300], 200);

        clear_stats(); kick(256, 1000, r); wait_done(0);
        check("pos_mod10", mod_seen[10], 1010);
        check("pos_mod22", mod_seen[22], 1022);
        check("pos_mod23", mod_seen[23], 1023);

        // Starts during a load must be ignored, gain must not change
        clear_stats(); kick(256, 0, r);
        repeat (10) begin @(posedge clk); #1; end
        cfg_gain = GW'(1000); cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
        repeat (489) begin @(posedge clk); #1; end
        cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
        wait_done(0);
        check("ign_strobes", strobe_cnt, 1024);
        check("ign_dones", done_cnt, 1);
        check("ign_mod700", mod_seen[700], 700);

        // Asynchronous reset mid-load, then a full reload
        clear_stats(); kick(384, 5, r);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (lut_bus.wr_stb && lut_bus.orig_px == PXW'(300)) hit = 1'b1;
        end
        check("rst_point_found", int'(hit), 1);
        #2 rst = 1'b1;
        #1;
        check("async_wr_stb", int'(lut_bus.wr_stb), 0);
        check("async_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        clear_stats(); kick(384, 5, r); wait_done(0);
        check("reload_strobes", strobe_cnt, 1024);
        check("reload_first_orig", first_orig, 0);
        check("reload_dones", done_cnt, 1);
        check("reload_mod300", mod_seen[300], 455);
        check("reload_mod1023", mod_seen[1023], 1023);

        for (int t = 0; t < 4; t++) begin
            clear_stats();
            kick(int'($urandom_range(0, 4095)), int'($urandom_range(0, 2047)) - 1024, r);
            wait_done(1);
            check("rand_strobes", strobe_cnt, 1024);
            check("rand_dones", done_cnt, 1);
        end

        repeat (5) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
